muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that extends the single-cycle combinational ALU with MIPS MULT/MULTU/DIV/DIVU and architectural HI/LO registers. It uses an iterative shift-add multiplier and a restoring divider, one result bit per cycle. A start/busy/done handshake lets the controller stall MFHI/MFLO until results are ready. It sits beside the ALU in the datapath: srca/srcb come from the register file, and hi/lo feed the writeback mux.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic                 divzero_q, divzero_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_sgn, b_sgn;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh, rem_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        a_sgn = ~op[0] & srca[WIDTH-1];
        b_sgn = ~op[0] & srcb[WIDTH-1];
        a_mag = a_sgn ? -srca : srca;
        b_mag = b_sgn ? -srcb : srcb;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        divzero_d = divzero_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                if (hilo_we[1]) hi_d = hilo_wdata;
                if (hilo_we[0]) lo_d = hilo_wdata;
                if (start) begin
                    op_d      = op;
                    divzero_d = 1'b0;
                    cnt_d     = '0;
                    neg_d     = a_sgn ^ b_sgn;
                    rneg_d    = a_sgn;
                    if (op[1]) begin
                        opnd_d  = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        dz_d    = (srcb == '0);
                        state_d = (srcb == '0) ? StFinish : StRun;
                    end else begin
                        opnd_d  = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (op_q[1]) begin
                    acc_d = {(rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (dz_q) begin
                    divzero_d = 1'b1;
                end else if (op_q[1]) begin
                    lo_d = quo;
                    hi_d = rem;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            divzero_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            divzero_q <= divzero_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign divzero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic [1:0]  hilo_we;
    logic [31:0] hilo_wdata;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .srca       (srca),
        .srcb       (srcb),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Present start in the low phase, return #1 after the edge where done rises.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int edges);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: done=%0b after %0d edges, required 1", done, edges);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %0b want 0", divzero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int e;
        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
        checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", e); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done: got %0b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %0b want 0", done); end
    endtask

    task automatic test_mult();
        int e;
        run_op(OpMult, 32'hFFFF_FFFD, 32'd7, e);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_div();
        int e;
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, e);
        checks++; if (e !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", e); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, e);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negdiv_hi: got %h want 00000001", hi); end
        run_op(OpDivu, 32'd7, 32'd2, e);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h want 3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", hi); end
        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, e);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_back_to_back();
        int e;
        run_op(OpDivu, 32'd100, 32'd7, e);
        run_op(OpMultu, 32'h0001_0000, 32'h0003_0000, e);
        checks++; if (e !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", e); end
        checks++; if (hi !== 32'h0000_0003) begin errors++; $display("FAIL b2b_hi: got %h want 3", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL b2b_lo: got %h want 0", lo); end
    endtask

    task automatic test_divzero();
        int e;
        @(negedge clk); hilo_we = 2'b10; hilo_wdata = 32'h1234;
        @(negedge clk); hilo_we = 2'b01; hilo_wdata = 32'h5678;
        @(negedge clk); hilo_we = 2'b00;
        run_op(OpDivu, 32'd9, 32'd0, e);
        checks++; if (e !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", e); end
        checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %0b want 1", divzero); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL dz_hi: got %h want 1234", hi); end
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL dz_lo: got %h want 5678", lo); end
        @(posedge clk); #1;
        checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_hold: got %0b want 1", divzero); end
        run_op(OpMultu, 32'd2, 32'd3, e);
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %0b want 0", divzero); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL dz_next_lo: got %h want 6", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi: got %h want 0", hi); end
    endtask

    task automatic test_busy();
        int e;
        @(negedge clk);
        op = OpMultu; srca = 32'd10; srcb = 32'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = OpMultu; srca = 32'd3; srcb = 32'd3; start = 1'b1;
        hilo_we = 2'b11; hilo_wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hilo_we = 2'b00;
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++; $display("FAIL busy_hilo_we: got hi=%h lo=%h want hi=0 lo=6", hi, lo);
        end
        e = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); e++; #1;
            if (done) break;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done: got %0b want 1", done); end
        checks++; if (lo !== 32'd100) begin errors++; $display("FAIL busy_ignore_lo: got %h want 64", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_ignore_hi: got %h want 0", hi); end
        hilo_we = 2'b01; hilo_wdata = 32'hABCD;
        @(posedge clk); #1 hilo_we = 2'b00;
        checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL done_cycle_mtlo: got %h want abcd", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL done_cycle_hi: got %h want 0", hi); end
    endtask

    task automatic test_mid_reset();
        int e;
        @(negedge clk);
        hilo_we = 2'b10; hilo_wdata = 32'h55;
        @(negedge clk);
        hilo_we = 2'b00;
        op = OpDiv; srca = 32'd100; srcb = 32'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        op = OpMult; srca = 32'hFFFF_FFFD; srcb = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %0b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %0b want 0", done); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL mid_divzero: got %0b want 0", divzero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mid_lo: got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b0;
        run_op(OpMultu, 32'd5, 32'd5, e);
        checks++; if (lo !== 32'd25) begin errors++; $display("FAIL post_reset_lo: got %h want 19", lo); end
        checks++; if (e !== 33) begin errors++; $display("FAIL post_reset_latency: got %0d want 33", e); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        hilo_we = 2'b00; hilo_wdata = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_back_to_back();
        test_divzero();
        test_busy();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
